// File: rtl/ram_slot_arbiter_if.sv
// Bus bundle between the slot arbiter, its requesters, the video shifter and the shared RAM.
// slave = arbiter side, master = environment (requesters, video, RAM) side.
interface ram_slot_arbiter_if #(
  parameter int ADDR_W  = 14,
  parameter int LANES   = 3,
  parameter int LANE_W  = 2,
  parameter int NUM_REQ = 2
) ();
  logic [4:0]              slot_phase;
  logic [ADDR_W-1:0]       video_addr;
  logic [LANES*8-1:0]      video_data;
  logic                    video_load;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LANE_W-1:0] req_lane;
  logic [NUM_REQ-1:0]      req_we;
  logic [NUM_REQ*2-1:0]    req_nib;
  logic [NUM_REQ*8-1:0]    req_wdata;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      done;
  logic [7:0]              rdata;
  logic [ADDR_W-1:0]       ram_addr;
  logic [LANES*2-1:0]      ram_we;
  logic [LANES*8-1:0]      ram_wdata;
  logic [LANES*8-1:0]      ram_rdata;

  modport slave (
    output slot_phase, video_data, video_load, grant, done, rdata,
           ram_addr, ram_we, ram_wdata,
    input  video_addr, req, req_addr, req_lane, req_we, req_nib, req_wdata,
           ram_rdata
  );

  modport master (
    input  slot_phase, video_data, video_load, grant, done, rdata,
           ram_addr, ram_we, ram_wdata,
    output video_addr, req, req_addr, req_lane, req_we, req_nib, req_wdata,
           ram_rdata
  );
endinterface

// File: rtl/ram_slot_arbiter.sv
// Time-sliced RAM controller: each slot is a fixed video word fetch followed by one
// arbitrated byte-lane access for a single requester.
module ram_slot_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int LANES       = 3,
  parameter int LANE_W      = 2,
  parameter int NUM_REQ     = 2,
  parameter int SLOT_CYCLES = 12,
  parameter int VIDEO_LEN   = 6,
  parameter int ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_slot_arbiter_if.slave bus
);

  localparam int PH_W  = 5;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [PH_W-1:0] PH_VCAP = PH_W'(1);
  localparam logic [PH_W-1:0] PH_ARB  = PH_W'(VIDEO_LEN - 1);
  localparam logic [PH_W-1:0] PH_WR   = PH_W'(VIDEO_LEN);
  localparam logic [PH_W-1:0] PH_RD   = PH_W'(VIDEO_LEN + 1);
  localparam logic [PH_W-1:0] PH_END  = PH_W'(SLOT_CYCLES - 1);

  logic [PH_W-1:0]      phase_q, phase_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [LANES*8-1:0]   video_data_q, video_data_d;
  logic                 video_load_q, video_load_d;
  logic [7:0]           rdata_q, rdata_d;

  logic                 win_any;
  logic [IDX_W-1:0]     win_idx, cand;
  logic [NUM_REQ-1:0]   winner;
  logic [IDX_W-1:0]     g_idx;
  logic [ADDR_W-1:0]    g_addr;
  logic [LANE_W-1:0]    g_lane;
  logic                 g_we;
  logic [1:0]           g_nib;
  logic [7:0]           g_wdata;

  // Lanes at or beyond LANES read back as zero.
  function automatic logic [7:0] lane_byte(input logic [LANES*8-1:0] word,
                                           input logic [LANE_W-1:0]  lane);
    lane_byte = 8'h00;
    for (int l = 0; l < LANES; l++)
      if (lane == LANE_W'(l)) lane_byte = word[l*8 +: 8];
  endfunction

  // Search starts at the pointer in rotating mode, at requester 0 otherwise.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (ROUND_ROBIN != 0) ? IDX_W'((int'(ptr_q) + k) % NUM_REQ) : IDX_W'(k);
      if (!win_any && bus.req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
    winner = win_any ? (NUM_REQ'(1) << win_idx) : '0;
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) g_idx = IDX_W'(i);
  end

  assign g_addr  = bus.req_addr[int'(g_idx)*ADDR_W +: ADDR_W];
  assign g_lane  = bus.req_lane[int'(g_idx)*LANE_W +: LANE_W];
  assign g_we    = bus.req_we[g_idx];
  assign g_nib   = bus.req_nib[int'(g_idx)*2 +: 2];
  assign g_wdata = bus.req_wdata[int'(g_idx)*8 +: 8];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q      <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      ptr_q        <= '0;
      video_data_q <= '0;
      video_load_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      phase_q      <= phase_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      ptr_q        <= ptr_d;
      video_data_q <= video_data_d;
      video_load_q <= video_load_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d      = (phase_q == PH_END) ? '0 : phase_q + PH_W'(1);
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    done_d       = (phase_q == PH_RD) ? grant_q : '0;
    video_load_d = (phase_q == PH_VCAP);
    video_data_d = (phase_q == PH_VCAP) ? bus.ram_rdata : video_data_q;
    rdata_d      = rdata_q;
    if (phase_q == PH_ARB) begin
      grant_d = winner;
      if (ROUND_ROBIN != 0 && win_any)
        ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end else if (phase_q == PH_END) begin
      grant_d = '0;
    end
    if (phase_q == PH_RD && |grant_q)
      rdata_d = lane_byte(bus.ram_rdata, g_lane);
  end

  // Output logic; reset also masks a write already presented to the RAM this cycle.
  always_comb begin
    bus.ram_addr = (phase_q < PH_WR || grant_q == '0) ? bus.video_addr : g_addr;
    bus.ram_we   = '0;
    if (rst_n && phase_q == PH_WR && |grant_q && g_we)
      for (int l = 0; l < LANES; l++)
        if (g_lane == LANE_W'(l)) bus.ram_we[l*2 +: 2] = g_nib;
    bus.ram_wdata  = {LANES{g_wdata}};
    bus.slot_phase = phase_q;
    bus.grant      = grant_q;
    bus.done       = done_q;
    bus.rdata      = rdata_q;
    bus.video_data = video_data_q;
    bus.video_load = video_load_q;
  end

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed bench: fixed-priority DUT on a 16k x 24 RAM model, plus a round-robin DUT.
module tb_ram_slot_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ram_slot_arbiter_if fx_if ();
  ram_slot_arbiter_if rr_if ();

  ram_slot_arbiter u_fx (.clk(clk), .rst_n(rst_n), .bus(fx_if.slave));
  ram_slot_arbiter #(.ROUND_ROBIN(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(rr_if.slave));

  logic [23:0] mem [0:16383];

  always @(posedge clk) begin
    fx_if.ram_rdata <= mem[fx_if.ram_addr];
    for (int l = 0; l < 3; l++)
      for (int n = 0; n < 2; n++)
        if (fx_if.ram_we[l*2+n])
          mem[fx_if.ram_addr][l*8+n*4 +: 4] <= fx_if.ram_wdata[l*8+n*4 +: 4];
  end

  assign rr_if.ram_rdata = '0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int p);
    int n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      step();
      n++;
      if (fx_if.slot_phase == 5'(p)) hit = 1'b1;
    end
    chk("phase_reach", 32'(hit), 32'd1);
  endtask

  task automatic fx_req(input int i, input logic r, input logic [13:0] a, input logic [1:0] ln,
                        input logic we, input logic [1:0] nib, input logic [7:0] wd);
    fx_if.req[i]             = r;
    fx_if.req_addr[i*14 +: 14] = a;
    fx_if.req_lane[i*2 +: 2] = ln;
    fx_if.req_we[i]          = we;
    fx_if.req_nib[i*2 +: 2]  = nib;
    fx_if.req_wdata[i*8 +: 8] = wd;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 24'h0;
    mem[14'h0105] = 24'hA1B2C3;
    mem[14'h0200] = 24'h123456;
    rst_n = 1'b0;
    fx_if.video_addr = 14'h0105;
    fx_if.req = '0; fx_if.req_addr = '0; fx_if.req_lane = '0;
    fx_if.req_we = '0; fx_if.req_nib = '0; fx_if.req_wdata = '0;
    rr_if.video_addr = 14'h0105;
    rr_if.req = '0; rr_if.req_addr = '0; rr_if.req_lane = '0;
    rr_if.req_we = '0; rr_if.req_nib = '0; rr_if.req_wdata = '0;

    repeat (3) begin
      step();
      chk("rst_phase", 32'(fx_if.slot_phase), 0);
      chk("rst_grant", 32'(fx_if.grant), 0);
      chk("rst_done", 32'(fx_if.done), 0);
      chk("rst_vload", 32'(fx_if.video_load), 0);
      chk("rst_rdata", 32'(fx_if.rdata), 0);
      chk("rst_vdata", 32'(fx_if.video_data), 0);
    end
    rst_n = 1'b1;

    for (int k = 1; k <= 24; k++) begin
      step();
      chk("cnt_phase", 32'(fx_if.slot_phase), 32'(k % 12));
      chk("idle_grant", 32'(fx_if.grant), 0);
      chk("idle_done", 32'(fx_if.done), 0);
      chk("vload", 32'(fx_if.video_load), 32'(k % 12 == 2));
      if (k >= 2) chk("vdata", 32'(fx_if.video_data), 32'h00A1B2C3);
    end

    // write low nibble of lane 1
    fx_req(0, 1, 14'h0105, 2'd1, 1, 2'b01, 8'h5E);
    go(6);
    chk("wr_grant", 32'(fx_if.grant), 32'b01);
    chk("wr_we", 32'(fx_if.ram_we), 32'b000100);
    chk("wr_addr", 32'(fx_if.ram_addr), 32'h0105);
    chk("wr_wdata", 32'(fx_if.ram_wdata), 32'h005E5E5E);
    go(7);
    chk("wr_we_off", 32'(fx_if.ram_we), 0);
    chk("wr_mem", 32'(mem[14'h0105]), 32'h00A1BEC3);
    go(8);
    chk("wr_done", 32'(fx_if.done), 32'b01);
    go(9);
    chk("wr_done_off", 32'(fx_if.done), 0);

    fx_req(0, 1, 14'h0105, 2'd1, 0, 2'b00, 8'h00);
    go(6);
    chk("rd_we", 32'(fx_if.ram_we), 0);
    chk("rd_addr", 32'(fx_if.ram_addr), 32'h0105);
    go(8);
    chk("rd_done", 32'(fx_if.done), 32'b01);
    chk("rd_data", 32'(fx_if.rdata), 32'hBE);
    go(9);
    chk("rd_hold", 32'(fx_if.rdata), 32'hBE);
    chk("rd_done_off", 32'(fx_if.done), 0);
    chk("vdata_new", 32'(fx_if.video_data), 32'h00A1BEC3);

    // fixed priority: both requesters held
    fx_req(0, 1, 14'h0105, 2'd0, 0, 2'b00, 8'h00);
    fx_req(1, 1, 14'h0105, 2'd2, 0, 2'b00, 8'h00);
    repeat (3) begin
      go(6);
      chk("fp_grant0", 32'(fx_if.grant), 32'b01);
      go(8);
      chk("fp_done0", 32'(fx_if.done), 32'b01);
      chk("fp_rdata0", 32'(fx_if.rdata), 32'hC3);
    end
    go(9);
    fx_req(0, 0, 14'h0105, 2'd0, 0, 2'b00, 8'h00);
    go(6);
    chk("fp_grant1", 32'(fx_if.grant), 32'b10);
    go(8);
    chk("fp_done1", 32'(fx_if.done), 32'b10);
    chk("fp_rdata1", 32'(fx_if.rdata), 32'hA1);

    // out-of-range lane and empty nibble mask
    go(9);
    fx_req(1, 1, 14'h0105, 2'd3, 0, 2'b00, 8'h00);
    go(8);
    chk("l3_done", 32'(fx_if.done), 32'b10);
    chk("l3_rdata", 32'(fx_if.rdata), 0);
    go(9);
    fx_req(1, 1, 14'h0105, 2'd3, 1, 2'b11, 8'hFF);
    go(6);
    chk("l3w_we", 32'(fx_if.ram_we), 0);
    go(8);
    chk("l3w_done", 32'(fx_if.done), 32'b10);
    chk("l3w_mem", 32'(mem[14'h0105]), 32'h00A1BEC3);
    go(9);
    fx_req(1, 1, 14'h0105, 2'd0, 1, 2'b00, 8'hFF);
    go(6);
    chk("n0_grant", 32'(fx_if.grant), 32'b10);
    chk("n0_we", 32'(fx_if.ram_we), 0);
    go(8);
    chk("n0_done", 32'(fx_if.done), 32'b10);
    chk("n0_mem", 32'(mem[14'h0105]), 32'h00A1BEC3);
    go(9);
    fx_req(1, 0, 14'h0105, 2'd0, 0, 2'b00, 8'h00);

    // request withdrawn before arbitration
    go(1);
    fx_req(0, 1, 14'h0105, 2'd2, 0, 2'b00, 8'h00);
    go(3);
    fx_req(0, 0, 14'h0105, 2'd2, 0, 2'b00, 8'h00);
    go(6);
    chk("drop_pre_grant", 32'(fx_if.grant), 0);
    go(8);
    chk("drop_pre_done", 32'(fx_if.done), 0);

    // request withdrawn after grant still completes
    go(0);
    fx_req(0, 1, 14'h0105, 2'd2, 0, 2'b00, 8'h00);
    go(6);
    chk("drop_post_grant", 32'(fx_if.grant), 32'b01);
    fx_req(0, 0, 14'h0105, 2'd2, 0, 2'b00, 8'h00);
    go(8);
    chk("drop_post_done", 32'(fx_if.done), 32'b01);
    chk("drop_post_rdata", 32'(fx_if.rdata), 32'hA1);

    // round robin with both requesters held
    go(9);
    rr_if.req = 2'b11;
    go(6);
    chk("rr_grant_a", 32'(rr_if.grant), 32'b01);
    go(6);
    chk("rr_grant_b", 32'(rr_if.grant), 32'b10);
    go(6);
    chk("rr_grant_c", 32'(rr_if.grant), 32'b01);

    // reset in the middle of a granted write
    fx_req(0, 1, 14'h0200, 2'd0, 1, 2'b11, 8'h77);
    go(6);
    chk("mid_grant", 32'(fx_if.grant), 32'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_we_masked", 32'(fx_if.ram_we), 0);
    step();
    chk("mid_phase", 32'(fx_if.slot_phase), 0);
    chk("mid_grant_clr", 32'(fx_if.grant), 0);
    chk("mid_rr_grant_clr", 32'(rr_if.grant), 0);
    chk("mid_done", 32'(fx_if.done), 0);
    chk("mid_mem", 32'(mem[14'h0200]), 32'h00123456);
    step();
    chk("mid_done2", 32'(fx_if.done), 0);
    fx_req(0, 0, 14'h0200, 2'd0, 0, 2'b00, 8'h00);
    rst_n = 1'b1;
    go(6);
    chk("post_rst_rr_ptr", 32'(rr_if.grant), 32'b01);
    chk("post_rst_fx_grant", 32'(fx_if.grant), 0);
    go(8);
    chk("post_rst_fx_done", 32'(fx_if.done), 0);
    chk("post_rst_rr_done", 32'(rr_if.done), 32'b01);
    chk("post_rst_mem", 32'(mem[14'h0200]), 32'h00123456);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
